fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 The block SHALL have port stall, input, 1, hazard-unit hold request for IF and IF/ID.
REQ-004 The block SHALL have port redirect_valid, input, 1, ID-stage branch/jump taken.
REQ-005 The block SHALL have port redirect_target, input, 32, next-PC target from ID.
REQ-006 The block SHALL have port instr_in, input, 32, instruction-memory word for pc_out (combinational).
REQ-007 The block SHALL have port pc_out, output, 32, current fetch PC driven to instruction memory.
REQ-008 The block SHALL have port if_id_instr, output, 32, latched instruction.
REQ-009 The block SHALL have port if_id_pc, output, 32, PC of the latched instruction.
REQ-010 The block SHALL have port if_id_valid, output, 1, latched instruction is real.
REQ-011 The block SHALL have port align_err, output, 1, sticky flag: misaligned redirect seen.
REQ-012 The block SHALL have port stall_cnt, output, 16, stall cycles since reset.
REQ-013 The block SHALL have parameter RESET_PC, default 32'h0000_3000, boot fetch address.

Function
REQ-014 The block SHALL implement states BOOT, RUN and HOLD in a state register.
REQ-015 BOOT SHALL be entered on reset and last exactly one cycle; next state RUN if stall=0, else HOLD.
REQ-016 RUN SHALL go to HOLD when stall=1; HOLD SHALL go to RUN when stall=0.
REQ-017 An unstalled edge SHALL load pc_out with the next PC: live redirect_target if redirect_valid=1, else the pending target if pend_valid=1, else pc_out+4.
REQ-018 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 SHALL wrap to 0.
REQ-019 An unstalled edge SHALL load if_id_instr<=instr_in, if_id_pc<=pc_out, if_id_valid<=1 (branch delay slot kept; no flush on redirect).
REQ-020 A stalled edge SHALL hold pc_out, if_id_instr, if_id_pc and if_id_valid unchanged.
REQ-021 A stalled edge with redirect_valid=1 SHALL capture redirect_target into a pending register and set pend_valid; a later capture SHALL overwrite it.
REQ-022 The first unstalled edge SHALL clear pend_valid whatever next-PC source is chosen.
REQ-023 A selected target with bits[1:0]!=0 SHALL be loaded with bits[1:0] forced to 00 and SHALL set align_err until reset.
REQ-024 stall_cnt SHALL increment on every edge with stall=1 outside reset and saturate at 16'hFFFF.
REQ-025 In BOOT, an unstalled edge SHALL fetch normally, except that if_id_valid SHALL stay 0 for that edge's IF/ID load only if instr_in is marked not valid; otherwise it SHALL set to 1.
REQ-026 Simultaneous stall=1 and redirect_valid=1 SHALL never change pc_out on that edge.

Reset
REQ-027 reset=1 at an edge SHALL set pc_out=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_valid=0, pend_valid=0, align_err=0, stall_cnt=0, and state=BOOT.
REQ-028 reset SHALL take priority over stall and redirect_valid.
REQ-029 Reset asserted mid-HOLD SHALL discard any pending target.

Verification
REQ-030 The bench SHALL release reset and run 3 free cycles -> pc_out 0x3000, 0x3004, 0x3008, 0x300C; if_id_pc lags pc_out by one cycle; if_id_valid=1 from cycle 2.
REQ-031 The bench SHALL assert redirect_valid with target 0x3040 while pc_out=0x3008 -> if_id_pc=0x3008 (delay slot) and pc_out=0x3040 on the next edge.
REQ-032 The bench SHALL assert stall for 3 cycles with a 1-cycle redirect to 0x3100 in the second stall cycle -> PC and IF/ID frozen; after release pc_out=0x3100; stall_cnt=3.
REQ-033 The bench SHALL redirect to 0x3102 -> pc_out=0x3100 and align_err=1 until reset.
REQ-034 The bench SHALL force pc_out to 0xFFFF_FFFC through a redirect -> next pc_out=0x0000_0000.
REQ-035 The bench SHALL assert reset during HOLD with pend_valid=1 -> pc_out=0x3000, if_id_valid=0, and no jump to the stale target after release.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer and its neighbours (hazard unit,
// ID stage, instruction memory). The slave modport is the sequencer's view.
interface fetch_sequencer_if;
  // redirect_valid has no ready. stall is the only back-pressure: a redirect
  // offered on a stalled edge is parked as a pending target, and the newest
  // redirect replaces an older one. It is then consumed on the next unstalled edge.
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        align_err;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;
  logic        dbg_pend_valid;

  modport master (
    output stall, redirect_valid, redirect_target, instr_in,
    input  pc_out, if_id_instr, if_id_pc, if_id_valid, align_err, stall_cnt,
    input  dbg_state, dbg_pend_valid
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, instr_in,
    output pc_out, if_id_instr, if_id_pc, if_id_valid, align_err, stall_cnt,
    output dbg_state, dbg_pend_valid
  );
endinterface

// File: rtl/fetch_sequencer.sv
// IF-stage PC sequencer with an IF/ID pipeline register. It keeps the delay slot
// on a redirect, parks a redirect that arrives during a stall, and counts stall cycles.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic              clk,
  input logic              reset,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_if_id_instr;
  logic [31:0] r_if_id_pc;
  logic        r_if_id_valid;
  logic [31:0] r_pend_target;
  logic        r_pend_valid;
  logic        r_align_err;
  logic [15:0] r_stall_cnt;

  logic        w_take_target;
  logic [31:0] w_target;
  logic        w_misaligned;
  logic [31:0] w_next_pc;

  // A live redirect wins over a parked one. Any chosen target is word-aligned.
  always_comb begin
    w_take_target = bus.redirect_valid | r_pend_valid;
    w_target      = bus.redirect_valid ? bus.redirect_target : r_pend_target;
    w_misaligned  = w_take_target && (w_target[1:0] != 2'b00);
    w_next_pc     = w_take_target ? {w_target[31:2], 2'b00} : (r_pc + 32'd4);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_if_id_instr <= 32'd0;
      r_if_id_pc    <= 32'd0;
      r_if_id_valid <= 1'b0;
      r_pend_target <= 32'd0;
      r_pend_valid  <= 1'b0;
      r_align_err   <= 1'b0;
      r_stall_cnt   <= 16'd0;
    end else begin
      case (r_state)
        BOOT:    r_state <= bus.stall ? HOLD : RUN;
        RUN:     r_state <= bus.stall ? HOLD : RUN;
        HOLD:    r_state <= bus.stall ? HOLD : RUN;
        default: r_state <= BOOT;
      endcase

      if (bus.stall) begin
        if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
        if (bus.redirect_valid) begin
          r_pend_target <= bus.redirect_target;
          r_pend_valid  <= 1'b1;
        end
      end else begin
        // The instruction at pc_out is always latched, even when redirecting.
        // That instruction is the delay slot.
        r_pc          <= w_next_pc;
        r_if_id_instr <= bus.instr_in;
        r_if_id_pc    <= r_pc;
        r_if_id_valid <= 1'b1;
        r_pend_valid  <= 1'b0;
        if (w_misaligned) r_align_err <= 1'b1;
      end
    end
  end

  assign bus.pc_out         = r_pc;
  assign bus.if_id_instr    = r_if_id_instr;
  assign bus.if_id_pc       = r_if_id_pc;
  assign bus.if_id_valid    = r_if_id_valid;
  assign bus.align_err      = r_align_err;
  assign bus.stall_cnt      = r_stall_cnt;
  assign bus.dbg_state      = r_state;
  assign bus.dbg_pend_valid = r_pend_valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Each step pushes its hand-computed
// post-edge snapshot, and a monitor checks it on the following falling edge.
module tb_fetch_sequencer;
  localparam int W = 116;
  localparam logic [31:0] IMEM_KEY = 32'h1357_0000;
  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic clk;
  logic reset;
  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // The instruction memory model returns a word derived from the address.
  assign bus.instr_in = bus.pc_out ^ IMEM_KEY;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec = 0;
  int           n_bad = 0;

  function automatic logic [W-1:0] pack(input logic [31:0] pc, input logic [31:0] ifpc,
                                        input logic v, input logic al,
                                        input logic [15:0] sc, input logic [1:0] st);
    logic [31:0] ins;
    ins = v ? (ifpc ^ IMEM_KEY) : 32'd0;
    return {pc, ifpc, ins, v, al, sc, st};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {bus.pc_out, bus.if_id_pc, bus.if_id_instr, bus.if_id_valid,
            bus.align_err, bus.stall_cnt, bus.dbg_state};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got pc=%h ifpc=%h instr=%h v=%b al=%b sc=%0d st=%0d, expected pc=%h ifpc=%h instr=%h v=%b al=%b sc=%0d st=%0d",
                 nm, a[115:84], a[83:52], a[51:20], a[19], a[18], a[17:2], a[1:0],
                 e[115:84], e[83:52], e[51:20], e[19], e[18], e[17:2], e[1:0]);
      end
    end
  end

  // driver
  task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] tgt,
                      input logic [31:0] e_pc, input logic [31:0] e_ifpc, input logic e_v,
                      input logic e_al, input logic [15:0] e_sc, input logic [1:0] e_st,
                      input string nm);
    @(negedge clk);
    reset               = rst;
    bus.stall           = st;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    @(posedge clk);
    #1;
    exp_q.push_back(pack(e_pc, e_ifpc, e_v, e_al, e_sc, e_st));
    name_q.push_back(nm);
  endtask

  initial begin
    reset               = 1'b1;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'd0;

    // reset priority, then plain reset, then free-running fetch
    step(1, 1, 1, 32'h5000, 32'h3000, 32'h0, 0, 0, 0, S_BOOT, "reset_prio");
    step(1, 0, 0, 32'h0,    32'h3000, 32'h0, 0, 0, 0, S_BOOT, "reset");
    step(0, 0, 0, 32'h0,    32'h3004, 32'h3000, 1, 0, 0, S_RUN, "free1");
    step(0, 0, 0, 32'h0,    32'h3008, 32'h3004, 1, 0, 0, S_RUN, "free2");
    step(0, 0, 0, 32'h0,    32'h300C, 32'h3008, 1, 0, 0, S_RUN, "free3");

    // redirect with delay slot
    step(1, 0, 0, 32'h0,    32'h3000, 32'h0, 0, 0, 0, S_BOOT, "reset_run");
    step(0, 0, 0, 32'h0,    32'h3004, 32'h3000, 1, 0, 0, S_RUN, "j_pre1");
    step(0, 0, 0, 32'h0,    32'h3008, 32'h3004, 1, 0, 0, S_RUN, "j_pre2");
    step(0, 0, 1, 32'h3040, 32'h3040, 32'h3008, 1, 0, 0, S_RUN, "jump_delay_slot");

    // three stall cycles with a redirect parked in the middle one
    step(0, 1, 0, 32'h0,    32'h3040, 32'h3008, 1, 0, 1, S_HOLD, "hold1");
    step(0, 1, 1, 32'h3100, 32'h3040, 32'h3008, 1, 0, 2, S_HOLD, "hold2_redirect");
    step(0, 1, 0, 32'h0,    32'h3040, 32'h3008, 1, 0, 3, S_HOLD, "hold3");
    step(0, 0, 0, 32'h0,    32'h3100, 32'h3040, 1, 0, 3, S_RUN, "pend_taken");
    step(0, 0, 0, 32'h0,    32'h3104, 32'h3100, 1, 0, 3, S_RUN, "pend_cleared");

    // misaligned target and sticky flag
    step(0, 0, 1, 32'h3102, 32'h3100, 32'h3104, 1, 1, 3, S_RUN, "misaligned");
    step(0, 0, 0, 32'h0,    32'h3104, 32'h3100, 1, 1, 3, S_RUN, "align_sticky");

    // wrap at the top of the address space
    step(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h3104, 1, 1, 3, S_RUN, "to_top");
    step(0, 0, 0, 32'h0,    32'h0000_0000, 32'hFFFF_FFFC, 1, 1, 3, S_RUN, "wrap");
    step(0, 0, 0, 32'h0,    32'h0000_0004, 32'h0000_0000, 1, 1, 3, S_RUN, "after_wrap");

    // stalled redirect keeps pc; a later capture overwrites the parked target
    step(0, 1, 1, 32'h4000, 32'h4, 32'h0, 1, 1, 4, S_HOLD, "stall_redirect");
    step(0, 1, 1, 32'h4200, 32'h4, 32'h0, 1, 1, 5, S_HOLD, "pend_overwrite");
    step(0, 0, 0, 32'h0,    32'h4200, 32'h4, 1, 1, 5, S_RUN, "pend_newest");

    // a live redirect on release beats the parked one, which is then dropped
    step(0, 1, 1, 32'h5000, 32'h4200, 32'h4, 1, 1, 6, S_HOLD, "park_5000");
    step(0, 0, 1, 32'h6000, 32'h6000, 32'h4200, 1, 1, 6, S_RUN, "live_wins");
    step(0, 0, 0, 32'h0,    32'h6004, 32'h6000, 1, 1, 6, S_RUN, "parked_dropped");

    // reset during HOLD with a parked target
    step(0, 1, 1, 32'h7000, 32'h6004, 32'h6000, 1, 1, 7, S_HOLD, "park_7000");
    step(1, 1, 0, 32'h0,    32'h3000, 32'h0, 0, 0, 0, S_BOOT, "reset_in_hold");
    step(0, 0, 0, 32'h0,    32'h3004, 32'h3000, 1, 0, 0, S_RUN, "no_stale_jump");

    // BOOT going straight into HOLD
    step(1, 0, 0, 32'h0,    32'h3000, 32'h0, 0, 0, 0, S_BOOT, "reset_again");
    step(0, 1, 0, 32'h0,    32'h3000, 32'h0, 0, 0, 1, S_HOLD, "boot_stall");
    step(0, 0, 0, 32'h0,    32'h3004, 32'h3000, 1, 0, 1, S_RUN, "boot_release");

    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_bad++;
        $display("FAIL drain: got %0d pending checks, expected 0", exp_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
